msg_streamer: RTL and testbench



---
 rtl/msg_streamer_pkg.sv | 19 +
 rtl/msg_rom.sv | 18 +
 rtl/msg_streamer.sv | 63 ++++++
 tb/tb_msg_streamer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/msg_streamer_pkg.sv
// msg_streamer_pkg: shared FSM states, NUL constant and leading-NUL counter.
package msg_streamer_pkg;
  typedef enum logic {IDLE, SEND} state_t;
  localparam logic [7:0] NUL = 8'h00;
  localparam int MAX_CHARS = 64;
  function automatic int lead_nul(input logic [8*MAX_CHARS-1:0] v, input int n);
    int c;
    bit run;
    c = 0;
    run = 1'b1;
    for (int i = MAX_CHARS-1; i >= 0; i--) begin
      if (i < n) begin
        if (run && v[8*i +: 8] == NUL) c++;
        else run = 1'b0;
      end
    end
    return c;
  endfunction
endpackage

// File: rtl/msg_rom.sv
// msg_rom: index-to-message select, out-of-range indices clamp to the last message.
module msg_rom
  import msg_streamer_pkg::*;
#(
  parameter int NUM_MSG = 4,
  parameter int MSG_CHARS = 4,
  parameter logic [NUM_MSG*MSG_CHARS*8-1:0] MSG_TABLE = {"Mes3", "Mes2", "Mes1", "Mes0"},
  parameter int IDX_W = NUM_MSG > 1 ? $clog2(NUM_MSG) : 1
) (
  input  logic [IDX_W-1:0]       idx,
  output logic [8*MSG_CHARS-1:0] msg
);
  int sel;
  always_comb begin
    sel = int'(idx) >= NUM_MSG ? NUM_MSG-1 : int'(idx);
    msg = MSG_TABLE[sel*8*MSG_CHARS +: 8*MSG_CHARS];
  end
endmodule

// File: rtl/msg_streamer.sv
// msg_streamer: serialises a table message MSB character first over valid/ready,
// optionally suppressing leading NUL padding.
module msg_streamer
  import msg_streamer_pkg::*;
#(
  parameter int NUM_MSG = 4,
  parameter int MSG_CHARS = 4,
  parameter logic [NUM_MSG*MSG_CHARS*8-1:0] MSG_TABLE = {"Mes3", "Mes2", "Mes1", "Mes0"},
  parameter bit SKIP_NUL = 1'b1,
  parameter int IDX_W = NUM_MSG > 1 ? $clog2(NUM_MSG) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDX_W-1:0] req_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_char,
  output logic             out_last,
  output logic             busy
);
  localparam int W = 8*MSG_CHARS;
  localparam int CW = $clog2(MSG_CHARS+1);
  state_t state;
  logic [W-1:0] sh, msg;
  logic [CW-1:0] cnt, load;
  logic [8*MAX_CHARS-1:0] ext;
  int nul;
  msg_rom #(.NUM_MSG(NUM_MSG), .MSG_CHARS(MSG_CHARS), .MSG_TABLE(MSG_TABLE), .IDX_W(IDX_W)) u_rom (
    .idx(req_idx),
    .msg(msg)
  );
  // An all-NUL message still emits one NUL so every request ends with out_last.
  always_comb begin
    ext = '0;
    ext[W-1:0] = msg;
    nul = lead_nul(ext, MSG_CHARS);
    load = !SKIP_NUL ? CW'(MSG_CHARS) : nul == MSG_CHARS ? CW'(1) : CW'(MSG_CHARS - nul);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sh <= '0;
      cnt <= '0;
    end else if (state == IDLE) begin
      if (req_valid) begin
        sh <= msg << (8*(MSG_CHARS - int'(load)));
        cnt <= load;
        state <= SEND;
      end
    end else if (out_ready) begin
      sh <= sh << 8;
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) state <= IDLE;
    end
  end
  assign req_ready = state == IDLE;
  assign out_valid = state == SEND;
  assign busy = out_valid;
  assign out_char = sh[W-1 -: 8];
  assign out_last = out_valid && cnt == CW'(1);
endmodule

// File: tb/tb_msg_streamer.sv
// tb_msg_streamer: four configurations driven against a string-level reference model.
module tb_msg_streamer;
  localparam logic [47:0] M_HI = "hi", M_HO = "ho", M_MES2 = "Mes2";
  localparam logic [127:0] TAB_A = {"Mes3", "Mes2", "Mes1", "Mes0"};
  localparam logic [143:0] TAB_B = {M_MES2, M_HO, M_HI};
  localparam logic [47:0] TAB_D = {24'h004100, 24'h000000};
  localparam bit PAT [7] = '{1, 0, 0, 1, 0, 1, 1};
  logic clk = 0, rst = 1;
  logic [3:0] req_valid = '0, out_ready = '0, req_ready, out_valid, out_last, busy;
  logic [1:0] req_idx [4] = '{default: '0};
  logic [7:0] out_char [4];
  logic [255:0] tabs [4];
  int nums [4] = '{4, 3, 3, 2};
  int chars [4] = '{4, 6, 6, 3};
  bit skips [4] = '{1, 1, 0, 1};
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;

  msg_streamer u_a (.clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_idx(req_idx[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_char(out_char[0]), .out_last(out_last[0]), .busy(busy[0]));
  msg_streamer #(.NUM_MSG(3), .MSG_CHARS(6), .MSG_TABLE(TAB_B), .SKIP_NUL(1)) u_b (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_idx(req_idx[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_char(out_char[1]), .out_last(out_last[1]), .busy(busy[1]));
  msg_streamer #(.NUM_MSG(3), .MSG_CHARS(6), .MSG_TABLE(TAB_B), .SKIP_NUL(0)) u_c (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_idx(req_idx[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_char(out_char[2]), .out_last(out_last[2]), .busy(busy[2]));
  msg_streamer #(.NUM_MSG(2), .MSG_CHARS(3), .MSG_TABLE(TAB_D), .SKIP_NUL(1)) u_d (
    .clk(clk), .rst(rst), .req_valid(req_valid[3]), .req_ready(req_ready[3]),
    .req_idx(req_idx[3][0:0]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .out_char(out_char[3]), .out_last(out_last[3]), .busy(busy[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected character stream: pick the clamped message, read it leftmost first,
  // drop leading NULs when skipping, never return an empty stream.
  task automatic model(input int k, input int idx, output byte q[$]);
    int sel;
    byte b;
    q = {};
    sel = idx >= nums[k] ? nums[k]-1 : idx;
    for (int c = 0; c < chars[k]; c++) begin
      b = byte'(tabs[k][(sel*chars[k] + chars[k]-1-c)*8 +: 8]);
      if (!(skips[k] && q.size() == 0 && b == 8'h00)) q.push_back(b);
    end
    if (q.size() == 0) q.push_back(8'h00);
  endtask

  task automatic accept(input int k, input int idx, input bit hold);
    @(negedge clk);
    chk("accept_ready", req_ready[k], 1);
    req_valid[k] = 1;
    req_idx[k] = 2'(idx);
    @(negedge clk);
    req_valid[k] = hold;
  endtask

  task automatic drain(input int k, input int idx, input int mode, input bit hold);
    byte q[$];
    int got, cyc;
    bit rdy;
    got = 0;
    cyc = 0;
    model(k, idx, q);
    while (got < q.size() && cyc < 200) begin
      chk("valid", out_valid[k], 1);
      chk("char", out_char[k], q[got]);
      chk("last", out_last[k], got == q.size()-1);
      chk("busy", busy[k], 1);
      chk("ready_in_send", req_ready[k], 0);
      rdy = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : cyc < 7 ? PAT[cyc] : 1'b1;
      out_ready[k] = rdy;
      if (rdy) got++;
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 200) chk("timeout", 1, 0);
    out_ready[k] = 0;
    chk("turn_valid", out_valid[k], 0);
    chk("turn_ready", req_ready[k], 1);
    chk("turn_busy", busy[k], 0);
    if (mode == 0) chk("send_cycles", cyc, q.size());
  endtask

  task automatic run(input int k, input int idx, input int mode);
    accept(k, idx, 0);
    drain(k, idx, mode, 0);
  endtask

  initial begin
    int k, idx;
    tabs[0] = 256'(TAB_A);
    tabs[1] = 256'(TAB_B);
    tabs[2] = 256'(TAB_B);
    tabs[3] = 256'(TAB_D);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("rst_valid", out_valid[i], 0);
      chk("rst_ready", req_ready[i], 1);
      chk("rst_busy", busy[i], 0);
      chk("rst_char", out_char[i], 0);
      chk("rst_last", out_last[i], 0);
    end
    rst = 0;
    run(0, 1, 0);
    run(1, 3, 0);
    run(1, 0, 0);
    run(2, 0, 0);
    run(3, 0, 0);
    run(3, 1, 0);
    run(1, 2, 2);
    accept(0, 2, 1);
    drain(0, 2, 0, 1);
    @(negedge clk);
    req_valid[0] = 0;
    drain(0, 2, 0, 0);
    @(negedge clk);
    chk("single_restart", out_valid[0], 0);
    accept(0, 1, 0);
    out_ready[0] = 1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_char", out_char[0], 8'h73);
    #2 rst = 1;
    #1;
    chk("arst_valid", out_valid[0], 0);
    chk("arst_busy", busy[0], 0);
    chk("arst_ready", req_ready[0], 1);
    chk("arst_last", out_last[0], 0);
    @(negedge clk);
    rst = 0;
    out_ready[0] = 0;
    run(0, 3, 0);
    for (int n = 0; n < 30; n++) begin
      k = int'($urandom_range(0, 3));
      idx = int'($urandom_range(0, k == 3 ? 1 : 3));
      run(k, idx, 1);
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
